// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - frame-buffer RAM arbiter between VGA scan-out and a buffered host write port
module vga_fb_arbiter #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  input  logic              vblank_only,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  output logic              wr_idle,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data
);

  localparam int FB_SIZE = FB_W * FB_H;

  logic              visible;
  logic              disp_slot;
  logic              host_slot;
  logic              head_ok;
  logic              push;
  logic [ADDR_W-1:0] row_ext;
  logic [ADDR_W-1:0] disp_addr;

  logic [ADDR_W-1:0] fifo_addr [4];
  logic [DATA_W-1:0] fifo_data [4];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [2:0]        level;

  logic              rd_d1;
  logic              vis_d1;
  logic              vis_d2;
  logic [DATA_W-1:0] pix_reg;

  // Slot decisions depend only on the current screen position, so line/frame wrap needs no state.
  assign visible   = (h_count < 10'd640) && (v_count < 10'd480);
  assign disp_slot = visible && (h_count[1:0] == 2'b00);

  // Row times 160 as (row<<7)+(row<<5); each frame-buffer pixel covers a 4x4 screen block.
  assign row_ext   = ADDR_W'(v_count[9:2]);
  assign disp_addr = (row_ext << 7) + (row_ext << 5) + ADDR_W'(h_count[9:2]);

  // The host only gets cycles the display does not claim; rst gates it so mem_we drops at once.
  assign host_slot = !rst && !disp_slot && (level != 3'd0) &&
                     (!vblank_only || (v_count >= 10'd480));
  assign head_ok   = fifo_addr[rd_ptr] < ADDR_W'(FB_SIZE);

  assign wr_ready  = (level != 3'd4);
  assign wr_idle   = (level == 3'd0);
  assign push      = wr_valid && wr_ready;

  // RAM port mux: display read, host write, or idle with all fields zeroed.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_err    = 1'b0;
    if (!rst) begin
      if (disp_slot) begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end else if (host_slot) begin
        if (head_ok) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = fifo_addr[rd_ptr];
          mem_wdata = fifo_data[rd_ptr];
        end else begin
          wr_err = 1'b1;
        end
      end
    end
  end

  // FIFO storage; contents are meaningless while level is zero, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and fill level; a pushed entry becomes the head no earlier than the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      level  <= 3'd0;
    end else begin
      if (push)      wr_ptr <= wr_ptr + 2'd1;
      if (host_slot) rd_ptr <= rd_ptr + 2'd1;
      case ({push, host_slot})
        2'b10:   level <= level + 3'd1;
        2'b01:   level <= level - 3'd1;
        default: level <= level;
      endcase
    end
  end

  // Pixel pipeline: capture read data the cycle after the display read, and delay visible by two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_d1   <= 1'b0;
      vis_d1  <= 1'b0;
      vis_d2  <= 1'b0;
      pix_reg <= '0;
    end else begin
      rd_d1  <= disp_slot;
      vis_d1 <= visible;
      vis_d2 <= vis_d1;
      if (rd_d1) pix_reg <= mem_rdata;
    end
  end

  assign pix_valid = vis_d2;
  assign pix_data  = vis_d2 ? pix_reg : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - randomized self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;

  localparam int FB_SIZE = 19200;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_count, v_count;
  logic        vblank_only, wr_valid;
  logic        wr_ready, wr_err, wr_idle;
  logic [14:0] wr_addr;
  logic [8:0]  wr_data;
  logic        mem_en, mem_we;
  logic [14:0] mem_addr;
  logic [8:0]  mem_wdata, mem_rdata;
  logic        pix_valid;
  logic [8:0]  pix_data;

  vga_fb_arbiter dut (
    .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
    .vblank_only(vblank_only), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err), .wr_idle(wr_idle),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_valid(pix_valid), .pix_data(pix_data)
  );

  always #20 clk = ~clk;

  // Single-port synchronous RAM seen by the DUT.
  logic [8:0] ram [0:32767];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Reference model state.
  typedef struct {
    logic [14:0] a;
    logic [8:0]  d;
  } ent_t;
  ent_t       q[$];
  logic [8:0] ref_mem [0:32767];
  logic [8:0] latest;
  bit         pvq[$];
  logic [8:0] pdq[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d h=%0d v=%0d got=%0h exp=%0h", tag, cyc, h_count, v_count, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    latest = 9'd0;
    pvq = '{1'b0, 1'b0};
    pdq = '{9'd0, 9'd0};
  endtask

  task automatic reset_checks();
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_wr_idle", 32'(wr_idle), 32'd1);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
  endtask

  // One clock: drive inputs, check at the falling edge against the model, advance the model.
  task automatic do_cycle(input int h, input int v, input bit vbo, input bit wv,
                          input int wa, input int wd);
    bit vis, disp, allow, good, can_push;
    int daddr;
    logic e_en, e_we, e_err;
    logic [14:0] e_addr;
    logic [8:0]  e_wd;
    h_count = 10'(h); v_count = 10'(v); vblank_only = vbo;
    wr_valid = wv; wr_addr = wa[14:0]; wr_data = wd[8:0];
    @(negedge clk);
    vis   = (h < 640) && (v < 480);
    disp  = vis && (h % 4 == 0);
    daddr = (v / 4) * 160 + h / 4;
    allow = !disp && (q.size() > 0) && (!vbo || v >= 480);
    good  = allow && (q[0].a < FB_SIZE);
    e_en = 0; e_we = 0; e_err = 0; e_addr = '0; e_wd = '0;
    if (disp) begin
      e_en = 1; e_addr = 15'(daddr);
    end else if (good) begin
      e_en = 1; e_we = 1; e_addr = q[0].a; e_wd = q[0].d;
    end else if (allow) begin
      e_err = 1;
    end
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    chk("wr_err", 32'(wr_err), 32'(e_err));
    chk("wr_ready", 32'(wr_ready), 32'(q.size() != 4));
    chk("wr_idle", 32'(wr_idle), 32'(q.size() == 0));
    chk("pix_valid", 32'(pix_valid), 32'(pvq[0]));
    chk("pix_data", 32'(pix_data), 32'(pdq[0]));
    can_push = (q.size() != 4);
    if (disp) latest = ref_mem[daddr];
    if (allow) begin
      if (good) ref_mem[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (wv && can_push) q.push_back('{a: wa[14:0], d: wd[8:0]});
    void'(pvq.pop_front());
    void'(pdq.pop_front());
    pvq.push_back(vis);
    pdq.push_back(vis ? latest : 9'd0);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Sequential scan with random host traffic (percentages for writes and bad addresses).
  task automatic run_span(input int v0, input int h0, input int n, input bit vbo,
                          input int wpct, input int bpct);
    int h, v, wa;
    bit wv;
    h = h0; v = v0;
    for (int i = 0; i < n; i++) begin
      wv = ($urandom % 100) < wpct;
      if (($urandom % 100) < bpct) wa = FB_SIZE + int'($urandom % (32768 - FB_SIZE));
      else                         wa = int'($urandom % FB_SIZE);
      do_cycle(h, v, vbo, wv, wa, int'($urandom % 512));
      h++;
      if (h == 800) begin
        h = 0; v++;
        if (v == 525) v = 0;
      end
    end
  endtask

  initial begin
    int diffs;
    rst = 1'b1;
    h_count = '0; v_count = '0; vblank_only = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    for (int a = 0; a < 32768; a++) begin
      ram[a] = a[8:0];
      ref_mem[a] = a[8:0];
    end
    #4;
    reset_checks();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Scan-out with the preloaded pattern, with directed looks at block (2,1).
    run_span(0, 0, 800 * 4, 1'b0, 0, 0);
    run_span(4, 0, 8, 1'b0, 0, 0);
    for (int h = 8; h < 14; h++) begin
      h_count = 10'(h); v_count = 10'd4; wr_valid = 1'b0;
      #2;
      if (h == 8) begin
        chk("addr_8_4", 32'(mem_addr), 32'd162);
        chk("we_8_4", 32'(mem_we), 32'd0);
      end
      if (h >= 10) begin
        chk("pix_valid_blk", 32'(pix_valid), 32'd1);
        chk("pix_data_blk", 32'(pix_data), 32'd162);
      end
      do_cycle(h, 4, 1'b0, 1'b0, 0, 0);
    end
    run_span(4, 14, 686, 1'b0, 0, 0);
    h_count = 10'd700; #2;
    chk("pix_valid_hblank", 32'(pix_valid), 32'd0);
    chk("pix_data_hblank", 32'(pix_data), 32'd0);
    run_span(4, 700, 100 + 800 * 2, 1'b0, 0, 0);

    // FIFO fills during visible with vblank_only, drains in vertical blanking.
    run_span(479, 0, 10, 1'b1, 100, 0);
    #2;
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    run_span(479, 10, 840, 1'b1, 100, 0);
    run_span(490, 0, 10, 1'b1, 0, 0);

    // Interleaved writes during visible lines, then drain.
    run_span(10, 0, 2400, 1'b0, 40, 10);
    run_span(13, 700, 20, 1'b0, 0, 0);

    // Bad address followed by a good one.
    do_cycle(700, 10, 1'b0, 1'b1, FB_SIZE, 9'h055);
    do_cycle(701, 10, 1'b0, 1'b1, 5, 9'h1FF);
    run_span(10, 702, 10, 1'b0, 0, 0);
    chk("ram5", 32'(ram[5]), 32'h1FF);

    // Random screen positions and vblank_only toggling.
    for (int i = 0; i < 3000; i++) begin
      int wa;
      if (($urandom % 100) < 5) wa = FB_SIZE + int'($urandom % (32768 - FB_SIZE));
      else                      wa = int'($urandom % FB_SIZE);
      do_cycle(int'($urandom % 800), int'($urandom % 525), ($urandom % 4) == 0,
               ($urandom % 2) == 1, wa, int'($urandom % 512));
    end

    // Reset with three writes queued mid-line.
    run_span(500, 0, 10, 1'b0, 0, 0);
    do_cycle(100, 50, 1'b1, 1'b1, 300, 9'h0AA);
    do_cycle(101, 50, 1'b1, 1'b1, 301, 9'h0BB);
    do_cycle(102, 50, 1'b1, 1'b1, 302, 9'h0CC);
    h_count = 10'd105; v_count = 10'd50; vblank_only = 1'b0; wr_valid = 1'b0;
    #1;
    chk("pre_rst_mem_we", 32'(mem_we), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    reset_checks();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    run_span(50, 106, 800, 1'b0, 0, 0);
    run_span(478, 0, 1700, 1'b0, 0, 0);

    diffs = 0;
    for (int a = 0; a < FB_SIZE; a++)
      if (ram[a] !== ref_mem[a]) diffs++;
    chk("ram_image", 32'(diffs), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
